path_walker: RTL and testbench

- Consumer of the shortest-path finder output.
- Accepts a 9-bit path mask over the 3x3 grid, plus start and end nodes.
- Walks the marked cells from start to end and emits one move per handshake: direction and next node.
- On completion, reports the path length, or reports an error if the mask does not form a walkable route.

---
 rtl/path_pkg.sv | 35 +++
 rtl/path_neighbour_sel.sv | 49 ++++
 rtl/path_walker.sv | 141 ++++++++++++++
 tb/tb_path_walker.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/path_pkg.sv
`default_nettype none
// ==== path_pkg: grid constants, codes, FSM encoding, node helpers (rev 1.0) ====
package path_pkg;

  localparam int         GRID_N    = 3;
  localparam logic [1:0] MAX_COORD = 2'(GRID_N - 1);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [1:0] ERR_BAD_ENDPOINT = 2'd1;
  localparam logic [1:0] ERR_DEAD_END     = 2'd2;
  localparam logic [1:0] ERR_EXTRA_CELLS  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_WALK  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Node encoding is {y, x}; mask bit index is x*3+y.
  function automatic logic [3:0] node_idx(input logic [3:0] node);
    return {2'b00, node[1:0]} * 4'd3 + {2'b00, node[3:2]};
  endfunction

  function automatic logic [8:0] node_bit(input logic [3:0] node);
    return 9'b1 << node_idx(node);
  endfunction

endpackage
`default_nettype wire

// File: rtl/path_neighbour_sel.sv
`default_nettype none
// ==== path_neighbour_sel: first unvisited in-mask neighbour, UP>DOWN>LEFT>RIGHT (rev 1.0) ====
module path_neighbour_sel
  import path_pkg::*;
(
  input  logic [3:0] cur,
  input  logic [8:0] mask,
  input  logic [8:0] visited,
  output logic       found,
  output logic [1:0] dir,
  output logic [3:0] next_node
);

  logic [1:0] x;
  logic [1:0] y;
  logic [3:0] cand [4];
  logic [3:0] ok;

  assign x = cur[1:0];
  assign y = cur[3:2];

  assign cand[0] = {y, x - 2'd1};
  assign cand[1] = {y, x + 2'd1};
  assign cand[2] = {y - 2'd1, x};
  assign cand[3] = {y + 2'd1, x};

  // Range test comes first so wrapped coordinates never qualify.
  assign ok[0] = (x != 2'd0)     && (|(mask & node_bit(cand[0]))) && !(|(visited & node_bit(cand[0])));
  assign ok[1] = (x < MAX_COORD) && (|(mask & node_bit(cand[1]))) && !(|(visited & node_bit(cand[1])));
  assign ok[2] = (y != 2'd0)     && (|(mask & node_bit(cand[2]))) && !(|(visited & node_bit(cand[2])));
  assign ok[3] = (y < MAX_COORD) && (|(mask & node_bit(cand[3]))) && !(|(visited & node_bit(cand[3])));

  always_comb begin
    found     = 1'b0;
    dir       = DIR_UP;
    next_node = cur;
    if (ok[0]) begin
      found = 1'b1; dir = DIR_UP;    next_node = cand[0];
    end else if (ok[1]) begin
      found = 1'b1; dir = DIR_DOWN;  next_node = cand[1];
    end else if (ok[2]) begin
      found = 1'b1; dir = DIR_LEFT;  next_node = cand[2];
    end else if (ok[3]) begin
      found = 1'b1; dir = DIR_RIGHT; next_node = cand[3];
    end
  end

endmodule
`default_nettype wire

// File: rtl/path_walker.sv
`default_nettype none
// ==== path_walker: walks a 3x3 path mask start->end, one move per handshake (rev 1.0) ====
// Optional STRICT_PATH_CHECK_EN: unvisited mask cells at the end report err_code 3.
module path_walker
  import path_pkg::*;
#(
  parameter int N     = GRID_N,
  parameter int LEN_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [8:0]       path_matrix,
  input  logic [3:0]       start_node,
  input  logic [3:0]       end_node,
  input  logic             path_valid,
  output logic             path_ready,
  output logic             move_valid,
  input  logic             move_ready,
  output logic [1:0]       move_dir,
  output logic [3:0]       move_node,
  output logic             done,
  output logic [LEN_W-1:0] path_length,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam logic [1:0] LAST = 2'(N - 1);

  state_t           state, state_n;
  logic [8:0]       mask, visited, sel_vis;
  logic [3:0]       start_lat, end_lat, cur, sel_cur, cand_node;
  logic [LEN_W-1:0] step, step_n;
  logic [1:0]       cand_dir, code_n;
  logic             found, hs, accept, advance, at_end, extra, bad_ep;

  assign path_ready = (state == ST_IDLE);
  assign accept     = path_valid && path_ready;
  assign done       = (state == ST_DONE);
  assign err        = (state == ST_ERR);
  assign hs         = move_valid && move_ready;
  assign advance    = !move_valid || move_ready;

  // The selector looks one move ahead so a new move can be registered on the
  // same edge that consumes the current one.
  assign sel_cur = hs ? move_node : cur;
  assign sel_vis = hs ? (visited | node_bit(move_node)) : visited;
  assign step_n  = hs ? step + LEN_W'(1) : step;
  assign at_end  = (sel_cur == end_lat);

  assign bad_ep = (start_lat[1:0] > LAST) || (start_lat[3:2] > LAST) ||
                  (end_lat[1:0]   > LAST) || (end_lat[3:2]   > LAST) ||
                  !(|(mask & node_bit(start_lat))) || !(|(mask & node_bit(end_lat)));

`ifdef STRICT_PATH_CHECK_EN
  assign extra = (sel_vis != mask);
`else
  assign extra = 1'b0;
`endif

  path_neighbour_sel u_sel (
    .cur       (sel_cur),
    .mask      (mask),
    .visited   (sel_vis),
    .found     (found),
    .dir       (cand_dir),
    .next_node (cand_node)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    code_n  = ERR_DEAD_END;
    case (state)
      ST_IDLE:  if (accept) state_n = ST_CHECK;
      ST_CHECK: begin
        code_n  = ERR_BAD_ENDPOINT;
        state_n = bad_ep ? ST_ERR : ST_WALK;
      end
      ST_WALK: begin
        if (advance) begin
          if (at_end) begin
            if (extra) begin
              state_n = ST_ERR;
              code_n  = ERR_EXTRA_CELLS;
            end else begin
              state_n = ST_DONE;
            end
          end else if (!found) begin
            state_n = ST_ERR;
          end
        end
      end
      ST_DONE:  state_n = ST_IDLE;
      ST_ERR:   state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask        <= '0;
      visited     <= '0;
      start_lat   <= '0;
      end_lat     <= '0;
      cur         <= '0;
      step        <= '0;
      move_valid  <= 1'b0;
      move_dir    <= '0;
      move_node   <= '0;
      path_length <= '0;
      err_code    <= '0;
    end else begin
      if (accept) begin
        mask        <= path_matrix;
        start_lat   <= start_node;
        end_lat     <= end_node;
        cur         <= start_node;
        visited     <= node_bit(start_node);
        step        <= '0;
        path_length <= '0;
        err_code    <= '0;
      end
      if (state == ST_WALK && advance) begin
        cur        <= sel_cur;
        visited    <= sel_vis;
        step       <= step_n;
        move_valid <= found && !at_end;
        move_dir   <= cand_dir;
        move_node  <= cand_node;
      end
      if (state == ST_WALK && state_n == ST_DONE) path_length <= step_n;
      if (state_n == ST_ERR) err_code <= code_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_path_walker.sv
`default_nettype none
// ==== tb_path_walker: randomized walks checked against a coordinate-level reference walk (rev 1.0) ====
module tb_path_walker;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [8:0] path_matrix = '0;
  logic [3:0] start_node = '0;
  logic [3:0] end_node = '0;
  logic       path_valid = 1'b0;
  logic       path_ready;
  logic       move_valid;
  logic       move_ready = 1'b0;
  logic [1:0] move_dir;
  logic [3:0] move_node;
  logic       done;
  logic [3:0] path_length;
  logic       err;
  logic [1:0] err_code;

  path_walker #(.N(3), .LEN_W(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .path_matrix (path_matrix),
    .start_node  (start_node),
    .end_node    (end_node),
    .path_valid  (path_valid),
    .path_ready  (path_ready),
    .move_valid  (move_valid),
    .move_ready  (move_ready),
    .move_dir    (move_dir),
    .move_node   (move_node),
    .done        (done),
    .path_length (path_length),
    .err         (err),
    .err_code    (err_code)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk on (x,y) integer coordinates.
  int exp_dir[$];
  int exp_node[$];
  int exp_code;
  int exp_len;

  task automatic model(input logic [8:0] m, input logic [3:0] s, input logic [3:0] e);
    int sx, sy, ex, ey, cx, cy, nx, ny, hit;
    logic [8:0] vis;
    int dx[4] = '{-1, 1, 0, 0};
    int dy[4] = '{0, 0, -1, 1};
    exp_dir.delete();
    exp_node.delete();
    exp_code = 0;
    exp_len  = 0;
    sx = int'(s[1:0]); sy = int'(s[3:2]);
    ex = int'(e[1:0]); ey = int'(e[3:2]);
    if (sx > 2 || sy > 2 || ex > 2 || ey > 2 || !m[sx*3+sy] || !m[ex*3+ey]) begin
      exp_code = 1;
      return;
    end
    vis = '0;
    vis[sx*3+sy] = 1'b1;
    cx = sx; cy = sy;
    while (!(cx == ex && cy == ey)) begin
      hit = -1;
      for (int d = 0; d < 4; d++) begin
        if (hit < 0) begin
          nx = cx + dx[d]; ny = cy + dy[d];
          if (nx >= 0 && nx <= 2 && ny >= 0 && ny <= 2)
            if (m[nx*3+ny] && !vis[nx*3+ny]) hit = d;
        end
      end
      if (hit < 0) begin
        exp_code = 2;
        return;
      end
      cx += dx[hit]; cy += dy[hit];
      vis[cx*3+cy] = 1'b1;
      exp_dir.push_back(hit);
      exp_node.push_back(cy*4 + cx);
    end
    exp_len = exp_dir.size();
`ifdef STRICT_PATH_CHECK_EN
    if (vis != m) exp_code = 3;
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, path_ready, 1);
    check({tag, "_mvalid"}, move_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_mdir"}, move_dir, 0);
    check({tag, "_mnode"}, move_node, 0);
    check({tag, "_len"}, path_length, 0);
    check({tag, "_code"}, err_code, 0);
  endtask

  // bp < 0: hold move_ready low for 3 cycles before each move; else random.
  task automatic run_case(input logic [8:0] m, input logic [3:0] s, input logic [3:0] e,
                          input int bp, input int abort_after);
    int  idx, first, stall;
    bit  prev_stall, finished, rdy;
    model(m, s, e);
    @(negedge clock);
    check("ready_idle", path_ready, 1);
    path_matrix = m; start_node = s; end_node = e; path_valid = 1'b1; move_ready = 1'b0;
    @(posedge clock);
    #1 path_valid = 1'b0;
    idx = 0; first = -1; stall = 0; prev_stall = 0; finished = 0;
    for (int cyc = 0; cyc < 120 && !finished; cyc++) begin
      @(negedge clock);
      if (abort_after >= 0 && idx == abort_after) begin
        path_valid = 1'b0;
        move_ready = 1'b0;
        reset_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) begin
          @(negedge clock);
          check("abort_no_done", done, 0);
          check("abort_no_err", err, 0);
          check("abort_ready", path_ready, 1);
        end
        return;
      end
      if (cyc == 0) check("busy_ready", path_ready, 0);
      if (first < 0 && (move_valid || done || err)) begin
        first = cyc;
        check("latency", cyc, (exp_code == 1) ? 1 : 2);
      end
      if (prev_stall) check("mv_hold", move_valid, 1);
      // Garbage requests while busy must be ignored.
      path_valid  = 1'($urandom_range(0, 1));
      path_matrix = 9'($urandom);
      start_node  = 4'($urandom);
      end_node    = 4'($urandom);
      if (move_valid) begin
        if (idx < exp_dir.size()) begin
          check($sformatf("dir%0d", idx), move_dir, exp_dir[idx]);
          check($sformatf("node%0d", idx), move_node, exp_node[idx]);
        end else begin
          check("extra_move", idx, exp_dir.size());
        end
        if (bp < 0) rdy = (stall >= 3);
        else        rdy = ($urandom_range(0, bp) == 0);
        move_ready = rdy;
        if (rdy) begin idx++; stall = 0; end
        else     stall++;
        prev_stall = !rdy;
      end else begin
        move_ready = 1'($urandom_range(0, 1));
        prev_stall = 0;
      end
      if (done || err) begin
        path_valid = 1'b0;
        finished = 1;
        check("moves", idx, exp_dir.size());
        check("done", done, exp_code == 0);
        check("err", err, exp_code != 0);
        if (exp_code == 0) check("path_length", path_length, exp_len);
        else               check("err_code", err_code, exp_code);
      end
    end
    path_valid = 1'b0;
    if (!finished) begin
      check("timeout", 0, 1);
      return;
    end
    @(negedge clock);
    move_ready = 1'b0;
    check("pulse_done", done, 0);
    check("pulse_err", err, 0);
    check("back_idle", path_ready, 1);
    if (exp_code == 0) check("len_hold", path_length, exp_len);
    else               check("code_hold", err_code, exp_code);
  endtask

  initial begin
    logic [8:0] m;
    logic [3:0] s, e;
    repeat (3) @(negedge clock);
    check_reset_outputs("rst");
    reset_n = 1'b1;

    run_case(9'h127, 4'h0, 4'hA, 0, -1);   // L-path
    run_case(9'h001, 4'h0, 4'h0, 0, -1);   // trivial
    run_case(9'h105, 4'h0, 4'hA, 0, -1);   // dead end
    run_case(9'h127, 4'h3, 4'hA, 0, -1);   // x=3
    run_case(9'h126, 4'h0, 4'hA, 0, -1);   // start bit clear
    run_case(9'h127, 4'h0, 4'hA, -1, -1);  // backpressure
    run_case(9'h127, 4'h0, 4'hA, -1, 2);   // reset after move 2
    run_case(9'h167, 4'h0, 4'hA, 0, -1);   // extra cell
    run_case(9'h1FF, 4'h0, 4'hA, 1, -1);   // full grid serpentine

    repeat (200) begin
      m = ($urandom_range(0, 1) == 1) ? 9'($urandom | $urandom) : 9'($urandom);
      s = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
      e = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
      if ($urandom_range(0, 9) == 0) s[1:0] = 2'd3;
      if ($urandom_range(0, 9) == 0) e[3:2] = 2'd3;
      if ($urandom_range(0, 4) != 0) begin
        if (s[1:0] < 2'd3 && s[3:2] < 2'd3) m[int'(s[1:0])*3 + int'(s[3:2])] = 1'b1;
        if (e[1:0] < 2'd3 && e[3:2] < 2'd3) m[int'(e[1:0])*3 + int'(e[3:2])] = 1'b1;
      end
      run_case(m, s, e, $urandom_range(0, 3), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
